// File: rtl/amo_port_arbiter.sv
// amo_port_arbiter
// Shares the data cache's single AMO port between NR_PORTS requesters.
// A round-robin pick is made in IDLE, the winner's request is latched and
// presented to the cache in BUSY until mem_ack_i, and the ack/result are
// steered back combinationally to the granted requester.
// Optional watchdog: define AMO_ARB_TIMEOUT_EN to build the BUSY-cycle
// counter behind timeout_o; otherwise timeout_o is tied low.
// Payload widths default to riscv::PLEN (56), riscv::XLEN (64) and the
// 4-bit ariane_pkg::amo_t encoding (AMO_ADD = 4).
//
// state | meaning
// IDLE  | no transaction; arbitrate among req_i
// BUSY  | latched request presented to cache, waiting for mem_ack_i

module amo_port_arbiter #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned PLEN     = 56,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned AMO_W    = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NR_PORTS-1:0]                req_i,
    input  logic [NR_PORTS-1:0][AMO_W-1:0]     amo_op_i,
    input  logic [NR_PORTS-1:0][PLEN-1:0]      addr_i,
    input  logic [NR_PORTS-1:0][XLEN-1:0]      operand_i,
    input  logic [NR_PORTS-1:0][1:0]           size_i,
    output logic [NR_PORTS-1:0]                ack_o,
    output logic [XLEN-1:0]                    result_o,
    output logic                               mem_req_o,
    output logic [AMO_W-1:0]                   mem_amo_op_o,
    output logic [PLEN-1:0]                    mem_addr_o,
    output logic [XLEN-1:0]                    mem_operand_o,
    output logic [1:0]                         mem_size_o,
    input  logic                               mem_ack_i,
    input  logic [XLEN-1:0]                    mem_result_i,
    output logic                               busy_o,
    output logic [$clog2(NR_PORTS)-1:0]        grant_idx_o,
    output logic                               timeout_o
);

    localparam int unsigned IDX_W = $clog2(NR_PORTS);

    // Reject unsupported configurations at elaboration time.
    if (NR_PORTS < 2 || NR_PORTS > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("amo_port_arbiter: NR_PORTS must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [AMO_W-1:0]     op_q, op_d;
    logic [PLEN-1:0]      addr_q, addr_d;
    logic [XLEN-1:0]      operand_q, operand_d;
    logic [1:0]           size_q, size_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W:0]       cand;
    logic [IDX_W:0]       grant_inc;
    logic [IDX_W-1:0]     grant_next;
    logic                 done;

    assign done = (state_q == BUSY) && mem_ack_i;

    // Round-robin pick: first set req_i bit at or above rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NR_PORTS)) begin
                cand = cand - (IDX_W+1)'(NR_PORTS);
            end
            if (!sel_found && req_i[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer to the port after the current grant, wrapping at NR_PORTS.
    always_comb begin
        grant_inc  = {1'b0, grant_idx_q} + {{IDX_W{1'b0}}, 1'b1};
        grant_next = grant_inc[IDX_W-1:0];
        if (grant_inc >= (IDX_W+1)'(NR_PORTS)) begin
            grant_next = '0;
        end
    end

    // Next-state, grant and payload latch decisions.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        op_d        = op_q;
        addr_d      = addr_q;
        operand_d   = operand_q;
        size_d      = size_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = BUSY;
                    grant_idx_d = sel_idx;
                    op_d        = amo_op_i[sel_idx];
                    addr_d      = addr_i[sel_idx];
                    operand_d   = operand_i[sel_idx];
                    size_d      = size_i[sel_idx];
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and latched payload registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            operand_q   <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            operand_q   <= operand_d;
            size_q      <= size_d;
        end
    end

    // Ack and result are steered to the granted port only in the ack cycle.
    always_comb begin
        ack_o    = '0;
        result_o = '0;
        if (done) begin
            ack_o[grant_idx_q] = 1'b1;
            result_o           = mem_result_i;
        end
    end

    assign busy_o        = (state_q == BUSY);
    assign mem_req_o     = (state_q == BUSY);
    assign mem_amo_op_o  = op_q;
    assign mem_addr_o    = addr_q;
    assign mem_operand_o = operand_q;
    assign mem_size_o    = size_q;
    assign grant_idx_o   = grant_idx_q;

`ifdef AMO_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT) + 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;

    // Count BUSY cycles without ack; saturate at TIMEOUT, flag is sticky.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (state_q == IDLE) begin
            if (sel_found) begin
                to_cnt_d = '0;
            end
        end else if (!mem_ack_i && (to_cnt_q != TO_W'(TIMEOUT))) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (to_cnt_d == TO_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_amo_port_arbiter.sv
// Directed bench for amo_port_arbiter with NR_PORTS=2, TIMEOUT=16.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.

module tb_amo_port_arbiter;

    localparam int NR   = 2;
    localparam int PLEN = 56;
    localparam int XLEN = 64;
    localparam logic [3:0] AMO_ADD  = 4'd4;
    localparam logic [3:0] AMO_SWAP = 4'd3;

`ifdef AMO_ARB_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic [NR-1:0]              req_i;
    logic [NR-1:0][3:0]         amo_op_i;
    logic [NR-1:0][PLEN-1:0]    addr_i;
    logic [NR-1:0][XLEN-1:0]    operand_i;
    logic [NR-1:0][1:0]         size_i;
    logic [NR-1:0]              ack_o;
    logic [XLEN-1:0]            result_o;
    logic                       mem_req_o;
    logic [3:0]                 mem_amo_op_o;
    logic [PLEN-1:0]            mem_addr_o;
    logic [XLEN-1:0]            mem_operand_o;
    logic [1:0]                 mem_size_o;
    logic                       mem_ack_i;
    logic [XLEN-1:0]            mem_result_i;
    logic                       busy_o;
    logic                       grant_idx_o;
    logic                       timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    amo_port_arbiter #(
        .NR_PORTS (NR),
        .TIMEOUT  (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .amo_op_i      (amo_op_i),
        .addr_i        (addr_i),
        .operand_i     (operand_i),
        .size_i        (size_i),
        .ack_o         (ack_o),
        .result_o      (result_o),
        .mem_req_o     (mem_req_o),
        .mem_amo_op_o  (mem_amo_op_o),
        .mem_addr_o    (mem_addr_o),
        .mem_operand_o (mem_operand_o),
        .mem_size_o    (mem_size_o),
        .mem_ack_i     (mem_ack_i),
        .mem_result_i  (mem_result_i),
        .busy_o        (busy_o),
        .grant_idx_o   (grant_idx_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_i        = 1'b1;
        req_i        = '0;
        amo_op_i     = '0;
        addr_i       = '0;
        operand_i    = '0;
        size_i       = '0;
        mem_ack_i    = 1'b0;
        mem_result_i = '0;
        @(negedge clk_i);
        #1;
        n_checks++;
        if ({mem_req_o, busy_o, grant_idx_o, timeout_o, ack_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req/busy/gnt/to/ack=%b, want 000000",
                     {mem_req_o, busy_o, grant_idx_o, timeout_o, ack_o});
        end
        n_checks++;
        if ({mem_amo_op_o, mem_addr_o, mem_operand_o, mem_size_o, result_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got addr=%h op=%h operand=%h size=%b result=%h, want all 0",
                     mem_addr_o, mem_amo_op_o, mem_operand_o, mem_size_o, result_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single;
        req_i        = 2'b01;
        amo_op_i[0]  = AMO_ADD;
        addr_i[0]    = 56'h40;
        operand_i[0] = 64'h5;
        size_i[0]    = 2'b10;
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c0_req: got %b, want 0", mem_req_o);
        end
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                mem_ack_i    = 1'b1;
                mem_result_i = 64'h7;
            end
            #1;
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 56'h40 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL single_c%0d_mem: got req=%b addr=%h busy=%b, want 1 40 1",
                         c, mem_req_o, mem_addr_o, busy_o);
            end
            if (c < 4) begin
                n_checks++;
                if (ack_o !== 2'b00 || result_o !== 64'h0) begin
                    n_fail++;
                    $display("FAIL single_c%0d_noack: got ack=%b result=%h, want 00 0",
                             c, ack_o, result_o);
                end
                tick();
            end
        end
        n_checks++;
        if (ack_o !== 2'b01 || result_o !== 64'h7 || mem_amo_op_o !== AMO_ADD ||
            mem_operand_o !== 64'h5 || mem_size_o !== 2'b10) begin
            n_fail++;
            $display("FAIL single_ack: got ack=%b result=%h op=%h operand=%h size=%b, want 01 7 4 5 10",
                     ack_o, result_o, mem_amo_op_o, mem_operand_o, mem_size_o);
        end
        tick();
        mem_ack_i    = 1'b0;
        mem_result_i = '0;
        req_i        = 2'b00;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || ack_o !== 2'b00 || result_o !== 64'h0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c5_idle: got busy=%b ack=%b result=%h req=%b, want 0 00 0 0",
                     busy_o, ack_o, result_o, mem_req_o);
        end
    endtask

    task automatic test_simultaneous;
        // Fresh reset so arbitration starts from port 0.
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        addr_i[0] = 56'h100;
        addr_i[1] = 56'h200;
        amo_op_i[1] = AMO_SWAP;
        req_i = 2'b11;
        tick();
        #1;
        n_checks++;
        if (grant_idx_o !== 1'b0 || mem_addr_o !== 56'h100 || mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_first: got gnt=%b addr=%h req=%b, want 0 100 1",
                     grant_idx_o, mem_addr_o, mem_req_o);
        end
        tick();
        mem_ack_i    = 1'b1;
        mem_result_i = 64'hA0;
        #1;
        n_checks++;
        if (ack_o !== 2'b01 || result_o !== 64'hA0) begin
            n_fail++;
            $display("FAIL simul_ack0: got ack=%b result=%h, want 01 a0", ack_o, result_o);
        end
        tick();
        mem_ack_i = 1'b0;
        req_i     = 2'b10;
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_idle_gap: got busy=%b, want 0", busy_o);
        end
        tick();
        #1;
        n_checks++;
        if (grant_idx_o !== 1'b1 || mem_addr_o !== 56'h200 || mem_amo_op_o !== AMO_SWAP) begin
            n_fail++;
            $display("FAIL simul_second: got gnt=%b addr=%h op=%h, want 1 200 3",
                     grant_idx_o, mem_addr_o, mem_amo_op_o);
        end
        tick();
        mem_ack_i    = 1'b1;
        mem_result_i = 64'hB1;
        #1;
        n_checks++;
        if (ack_o !== 2'b10 || result_o !== 64'hB1) begin
            n_fail++;
            $display("FAIL simul_ack1: got ack=%b result=%h, want 10 b1", ack_o, result_o);
        end
        tick();
        mem_ack_i = 1'b0;
        req_i     = 2'b00;
        tick();
    endtask

    task automatic test_round_robin;
        // rr pointer is 0 after port 1's ack; port 0 wins first.
        addr_i[0] = 56'h300;
        addr_i[1] = 56'h400;
        req_i = 2'b01;
        tick();
        #1;
        n_checks++;
        if (grant_idx_o !== 1'b0 || mem_addr_o !== 56'h300) begin
            n_fail++;
            $display("FAIL rr_first: got gnt=%b addr=%h, want 0 300", grant_idx_o, mem_addr_o);
        end
        req_i     = 2'b11;
        addr_i[1] = 56'h444;
        tick();
        mem_ack_i = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 2'b01 || mem_addr_o !== 56'h300) begin
            n_fail++;
            $display("FAIL rr_ack0: got ack=%b addr=%h, want 01 300", ack_o, mem_addr_o);
        end
        tick();
        mem_ack_i = 1'b0;
        tick();
        #1;
        n_checks++;
        if (grant_idx_o !== 1'b1 || mem_addr_o !== 56'h444) begin
            n_fail++;
            $display("FAIL rr_second: got gnt=%b addr=%h, want 1 444", grant_idx_o, mem_addr_o);
        end
        mem_ack_i = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 2'b10) begin
            n_fail++;
            $display("FAIL rr_ack1: got ack=%b, want 10", ack_o);
        end
        tick();
        mem_ack_i = 1'b0;
        req_i     = 2'b01;
        tick();
        #1;
        n_checks++;
        if (grant_idx_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_third: got gnt=%b busy=%b, want 0 1", grant_idx_o, busy_o);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        req_i     = 2'b00;
        tick();
    endtask

    task automatic test_stray_ack;
        mem_ack_i    = 1'b1;
        mem_result_i = 64'hDEAD;
        #1;
        n_checks++;
        if (ack_o !== 2'b00 || result_o !== 64'h0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: got ack=%b result=%h busy=%b, want 00 0 0",
                     ack_o, result_o, busy_o);
        end
        tick();
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || ack_o !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_after: got busy=%b ack=%b, want 0 00", busy_o, ack_o);
        end
        mem_ack_i    = 1'b0;
        mem_result_i = '0;
    endtask

    task automatic test_reset_mid;
        // rr pointer is 1 here; grant port 1 and kill it with reset.
        addr_i[1] = 56'h555;
        req_i = 2'b10;
        tick();
        #1;
        n_checks++;
        if (busy_o !== 1'b1 || grant_idx_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy: got busy=%b gnt=%b, want 1 1", busy_o, grant_idx_o);
        end
        rst_i = 1'b1;
        req_i = 2'b00;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || grant_idx_o !== 1'b0 ||
            mem_addr_o !== 56'h0 || ack_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy=%b req=%b gnt=%b addr=%h ack=%b, want 0 0 0 0 00",
                     busy_o, mem_req_o, grant_idx_o, mem_addr_o, ack_o);
        end
        tick();
        rst_i     = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 2'b00 || result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL rstmid_lateack: got ack=%b result=%h, want 00 0", ack_o, result_o);
        end
        tick();
        mem_ack_i = 1'b0;
        req_i     = 2'b11;
        tick();
        #1;
        n_checks++;
        if (grant_idx_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got gnt=%b busy=%b, want 0 1", grant_idx_o, busy_o);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        req_i     = 2'b00;
        tick();
    endtask

    task automatic test_timeout;
        addr_i[0] = 56'h80;
        req_i = 2'b01;
        tick();
        // Requester drops early; the latched transaction must still complete.
        req_i = 2'b00;
        for (int c = 1; c < 16; c++) begin
            tick();
        end
        #1;
        n_checks++;
        if (timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_c16: got %b, want 0", timeout_o);
        end
        tick();
        #1;
        n_checks++;
        if (timeout_o !== EXP_TO || mem_req_o !== 1'b1 || mem_addr_o !== 56'h80) begin
            n_fail++;
            $display("FAIL timeout_c17: got to=%b req=%b addr=%h, want %b 1 80",
                     timeout_o, mem_req_o, mem_addr_o, EXP_TO);
        end
        mem_ack_i    = 1'b1;
        mem_result_i = 64'h99;
        #1;
        n_checks++;
        if (ack_o !== 2'b01 || result_o !== 64'h99) begin
            n_fail++;
            $display("FAIL timeout_ack: got ack=%b result=%h, want 01 99", ack_o, result_o);
        end
        tick();
        mem_ack_i = 1'b0;
        tick();
        #1;
        n_checks++;
        if (timeout_o !== EXP_TO || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: got to=%b busy=%b, want %b 0",
                     timeout_o, busy_o, EXP_TO);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_stray_ack();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
